// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle bfloat16 adder sequencer.
// Orders operands by magnitude, aligns the smaller one a bit per cycle,
// adds/subtracts, left-normalizes a bit per cycle, then hands the sum to
// add_renorm (right renormalize + round-to-nearest-even) and registers it.
// Ports:
//   clk, rst       rising-edge clock, async active-high reset
//   start          one-cycle request, sampled only in IDLE
//   a, b           bfloat16 operands {sign, exp[7:0], frac[6:0]}
//   busy           high from the cycle after acceptance through DONE
//   done           one-cycle pulse, result valid
//   result         packed sum, held until overwritten by the next operation

// add_renorm: right renormalization on carry-out, then RNE rounding.
// mantissa is {carry, hidden, frac[6:0], guard, round, sticky}.
module add_renorm (
  input  logic [11:0] mantissa,
  input  logic [7:0]  exp,
  output logic [6:0]  mantissa_r,
  output logic [7:0]  exp_r
);
  logic [10:0] m1;
  logic [7:0]  e1;
  logic        rnd;
  logic [8:0]  m9;

  always_comb begin
    // Carry out: shift right once, folding the dropped bit into sticky.
    if (mantissa[11]) begin
      m1 = {mantissa[11:2], mantissa[1] | mantissa[0]};
      e1 = exp + 8'd1;
    end else begin
      m1 = mantissa[10:0];
      e1 = exp;
    end
    rnd = m1[2] & (m1[1] | m1[0] | m1[3]);
    m9  = {1'b0, m1[10:3]} + {8'd0, rnd};
    // Rounding overflow (1.1111111 + ulp) renormalizes to 1.0 at exp+1.
    if (m9[8]) begin
      mantissa_r = m9[7:1];
      exp_r      = e1 + 8'd1;
    end else begin
      mantissa_r = m9[6:0];
      exp_r      = e1;
    end
  end
endmodule

module fp_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);
  localparam int unsigned FpW  = 16;
  localparam int unsigned ExpW = 8;
  localparam int unsigned ManW = 11;
  localparam int unsigned SumW = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_SWAP, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [FpW-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic              sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ExpW-1:0]   exp_q, exp_d, d_q, d_d;
  logic [ManW-1:0]   mx_q, mx_d, my_q, my_d;
  logic [SumW-1:0]   sum_q, sum_d;

  // Operand ordering helpers, evaluated on the latched operands.
  logic              a_zero, b_zero, a_ge_b, mag_eq;
  logic [FpW-1:0]    x_op, y_op;
  logic [ExpW-1:0]   diff;
  logic [SumW-1:0]   add_sum;
  logic [6:0]        rn_frac;
  logic [ExpW-1:0]   rn_exp;

  always_comb begin
    a_zero  = (a_q[14:7] == 8'd0);
    b_zero  = (b_q[14:7] == 8'd0);
    a_ge_b  = (a_q[14:0] >= b_q[14:0]);
    mag_eq  = (a_q[14:0] == b_q[14:0]);
    x_op    = a_ge_b ? a_q : b_q;
    y_op    = a_ge_b ? b_q : a_q;
    diff    = x_op[14:7] - y_op[14:7];
    add_sum = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                        : ({1'b0, mx_q} + {1'b0, my_q});
  end

  add_renorm u_renorm (
    .mantissa   (sum_q),
    .exp        (exp_q),
    .mantissa_r (rn_frac),
    .exp_r      (rn_exp)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    d_d       = d_q;
    mx_d      = mx_q;
    my_d      = my_q;
    sum_d     = sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        sign_d    = x_op[15];
        eff_sub_d = a_q[15] ^ b_q[15];
        exp_d     = x_op[14:7];
        d_d       = diff;
        mx_d      = {1'b1, x_op[6:0], 3'b000};
        my_d      = {1'b1, y_op[6:0], 3'b000};
        if (a_zero && b_zero) begin
          result_d = 16'h0000;
          state_d  = S_DONE;
        end else if (a_zero) begin
          result_d = b_q;
          state_d  = S_DONE;
        end else if (b_zero) begin
          result_d = a_q;
          state_d  = S_DONE;
        end else if ((a_q[15] ^ b_q[15]) && mag_eq) begin
          result_d = 16'h0000;
          state_d  = S_DONE;
        end else if (diff != 8'd0) begin
          state_d = S_ALIGN;
        end else begin
          state_d = S_ADD;
        end
      end
      S_ALIGN: begin
        // Far-apart exponents: Y only contributes a sticky bit.
        if (d_q > 8'd11) begin
          my_d    = 11'd1;
          d_d     = 8'd0;
          state_d = S_ADD;
        end else begin
          my_d = {1'b0, my_q[10:2], my_q[1] | my_q[0]};
          d_d  = d_q - 8'd1;
          if (d_q == 8'd1) state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d = add_sum;
        if (eff_sub_q && !add_sum[10]) state_d = S_NORM;
        else                           state_d = S_ROUND;
      end
      S_NORM: begin
        // Another left shift would take the exponent to 0: flush.
        if (exp_q == 8'd1) begin
          result_d = 16'h0000;
          state_d  = S_DONE;
        end else begin
          sum_d = {sum_q[10:0], 1'b0};
          exp_d = exp_q - 8'd1;
          if (sum_q[9]) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d = {sign_q, rn_exp, rn_frac};
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exp_q     <= '0;
      d_q       <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      exp_q     <= exp_d;
      d_q       <= d_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      sum_q     <= sum_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: self-checking bench for fp_add_seq.
// Directed vectors, randomized operands against an exact-arithmetic
// reference, protocol checks (ignored starts, mid-operation reset).
module tb_fp_add_seq;
  localparam int MAX_WAIT = 600;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed sum of the two values, then RNE to 8-bit
  // significand, flush to zero below exponent 1. Latency from the
  // alignment distance and the number of left-normalization shifts.
  function automatic void ref_add(input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] res, output int lat);
    int ea, eb, emin, ex, d, alat, p, e, sh, k;
    longint sa, sb, s, mag, q, rem, half;
    ea = int'(av[14:7]);
    eb = int'(bv[14:7]);
    res = 16'h0000;
    lat = 2;
    if (ea == 0 && eb == 0) return;
    if (ea == 0) begin res = bv; return; end
    if (eb == 0) begin res = av; return; end
    ex   = (av[14:0] >= bv[14:0]) ? ea : eb;
    d    = (ea > eb) ? ea - eb : eb - ea;
    alat = (d == 0) ? 0 : ((d <= 11) ? d : 1);
    emin = (ea < eb) ? ea : eb;
    sa = longint'({1'b1, av[6:0]}) <<< (ea - emin);
    sb = longint'({1'b1, bv[6:0]}) <<< (eb - emin);
    if (av[15]) sa = -sa;
    if (bv[15]) sb = -sb;
    s = sa + sb;
    if (s == 0) return;
    mag = (s < 0) ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = emin + p - 7;
    if (e < 1) begin
      lat = 3 + alat + ex;
      return;
    end
    k = (ex > e) ? ex - e : 0;
    if (p > 7) begin
      sh   = p - 7;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (7 - p);
    end
    if (q == 256) begin
      q = 128;
      e = e + 1;
    end
    res = {(s < 0), 8'(e), 7'(q)};
    lat = 4 + alat + k;
  endfunction

  // Drive one request and wait for done; lat = -1 if it never came.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        output logic [15:0] res, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat = -1;
    @(negedge clk);
    a_i = av;
    b_i = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a_i = 16'h0;
    b_i = 16'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b result=%h, required 0 0 0000", busy, done, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h3F80, 16'h3F80, 16'h4040, 16'h0000, 16'h3F80};
    logic [15:0] vb [5] = '{16'h3F80, 16'hBF00, 16'hC040, 16'h4049, 16'h3580};
    logic [15:0] vr [5] = '{16'h4000, 16'h3F00, 16'h0000, 16'h4049, 16'h3F80};
    int          vl [5] = '{4, 6, 2, 2, 5};
    logic [15:0] res;
    int lat;
    bit bok;
    for (int i = 0; i < 5; i++) begin
      for (int sw = 0; sw < 2; sw++) begin
        if (sw == 0) run_op(va[i], vb[i], res, lat, bok);
        else         run_op(vb[i], va[i], res, lat, bok);
        n_checks++;
        if (res !== vr[i]) begin
          n_fail++;
          $display("FAIL directed_result[%0d,%0d]: got %h, required %h", i, sw, res, vr[i]);
        end
        n_checks++;
        if (lat != vl[i]) begin
          n_fail++;
          $display("FAIL directed_latency[%0d,%0d]: got %0d, required %0d", i, sw, lat, vl[i]);
        end
        n_checks++;
        if (!bok) begin
          n_fail++;
          $display("FAIL directed_busy[%0d,%0d]: busy dropped before done, required high", i, sw);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] av, bv, res, exp_res;
    int lat, exp_lat, ea, eb, fa, fb, sa, sb, mode;
    bit bok;
    for (int it = 0; it < 200; it++) begin
      mode = int'($urandom_range(0, 7));
      sa = int'($urandom_range(0, 1));
      sb = int'($urandom_range(0, 1));
      fa = int'($urandom_range(0, 127));
      fb = int'($urandom_range(0, 127));
      ea = int'($urandom_range(1, 200));
      eb = ea + int'($urandom_range(0, 30)) - 15;
      if (mode == 1) begin
        eb = ea;
        sb = 1 - sa;
        fb = fa ^ int'($urandom_range(0, 3));
      end else if (mode == 2) begin
        ea = int'($urandom_range(1, 5));
        eb = ea - int'($urandom_range(0, 1));
        sb = 1 - sa;
        fb = fa ^ int'($urandom_range(0, 15));
      end
      if (eb < 1) eb = 1;
      if (eb > 200) eb = 200;
      if (mode == 0) eb = 0;
      av = {1'(sa), 8'(ea), 7'(fa)};
      bv = {1'(sb), 8'(eb), 7'(fb)};
      if ($urandom_range(0, 1) == 1) begin
        res = av;
        av = bv;
        bv = res;
      end
      ref_add(av, bv, exp_res, exp_lat);
      run_op(av, bv, res, lat, bok);
      n_checks++;
      if (res !== exp_res) begin
        n_fail++;
        $display("FAIL random_result a=%h b=%h: got %h, required %h", av, bv, res, exp_res);
      end
      n_checks++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL random_latency a=%h b=%h: got %0d, required %0d", av, bv, lat, exp_lat);
      end
      n_checks++;
      if (!bok) begin
        n_fail++;
        $display("FAIL random_busy a=%h b=%h: busy dropped before done", av, bv);
      end
    end
  endtask

  // start while busy and start coincident with done are both ignored.
  task automatic test_start_ignored();
    int lat;
    lat = -1;
    @(negedge clk);
    a_i = 16'h3F80;
    b_i = 16'hBF00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      start = (n == 2);
      if (n == 2) begin
        a_i = 16'h4040;
        b_i = 16'h4040;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (result !== 16'h3F00 || lat != 6) begin
      n_fail++;
      $display("FAIL start_while_busy: result=%h lat=%0d, required 3f00 6", result, lat);
    end
    a_i = 16'h4049;
    b_i = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h3F00) begin
      n_fail++;
      $display("FAIL start_with_done: busy=%b done=%b result=%h, required 0 0 3f00", busy, done, result);
    end
  endtask

  task automatic test_reset_mid_align();
    logic [15:0] res;
    int lat;
    bit bok, seen;
    @(negedge clk);
    a_i = 16'h4380;
    b_i = 16'h3F80;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_align: busy=%b done=%b result=%h, required 0 0 0000", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_discard: done/busy seen after reset, required none");
    end
    run_op(16'h4380, 16'h3F80, res, lat, bok);
    n_checks++;
    if (res !== 16'h4380 || lat != 12) begin
      n_fail++;
      $display("FAIL after_reset_op: result=%h lat=%0d, required 4380 12", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_align();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
